alu_chunk_sequencer: RTL and testbench

Multi-cycle controller that performs wide add/subtract by time-multiplexing the narrow `ALU` (slice width `TERMINAL_RANGE`) over `NUM_CHUNKS` consecutive cycles. It latches wide operands on a start handshake and drives one ALU slice per cycle, least-significant chunk first. The ALU carry-out of each chunk is chained into the next chunk's carry-in. The block sits between the CPU control path and a single `ALU` instance, and owns that instance's inputs.

---
 rtl/alu_chunk_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_chunk_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_chunk_sequencer.sv
// rtl/alu_chunk_sequencer.sv - drives a narrow ALU slice-by-slice to perform wide add/subtract
module alu_chunk_sequencer #(
    parameter int TERMINAL_RANGE = 4,
    parameter int NUM_CHUNKS     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          op,
    input  logic [TERMINAL_RANGE*NUM_CHUNKS-1:0] a,
    input  logic [TERMINAL_RANGE*NUM_CHUNKS-1:0] b,
    input  logic                          cin_in,
    output logic                          busy,
    output logic                          done,
    output logic [TERMINAL_RANGE*NUM_CHUNKS-1:0] result,
    output logic                          cout,
    output logic                          zero,
    output logic [TERMINAL_RANGE-1:0]     alu_a,
    output logic [TERMINAL_RANGE-1:0]     alu_b,
    output logic                          alu_cin,
    output logic                          alu_op,
    input  logic [TERMINAL_RANGE-1:0]     alu_product,
    input  logic                          alu_cout,
    input  logic                          alu_zero
);

    localparam int W    = TERMINAL_RANGE * NUM_CHUNKS;
    localparam int IDXW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            op_q;
    logic            cin_q;
    logic            carry_q;
    logic            zacc_q;
    logic [IDXW-1:0] idx_q;
    logic [W-1:0]    work_q;
    logic [W-1:0]    work_next;
    int              base;

    // Status flags are plain decodes of the registered state.
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

    // Work word with the current ALU slice merged in; the final edge stores this whole word.
    always_comb begin
        base      = int'(idx_q) * TERMINAL_RANGE;
        work_next = work_q;
        work_next[base +: TERMINAL_RANGE] = alu_product;
    end

    // ALU inputs: current operand slice while running, quiet zeros otherwise.
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        alu_op  = 1'b0;
        if (state_q == S_RUN) begin
            alu_a   = a_q[base +: TERMINAL_RANGE];
            alu_b   = b_q[base +: TERMINAL_RANGE];
            alu_op  = op_q;
            alu_cin = (idx_q == '0) ? cin_q : carry_q;
        end
    end

    // Sequencer FSM: accept operands, walk chunks LSB first, publish the result on the last chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            idx_q   <= '0;
            work_q  <= '0;
            result  <= '0;
            cout    <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        cin_q   <= cin_in;
                        idx_q   <= '0;
                        zacc_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    work_q  <= work_next;
                    carry_q <= alu_cout;
                    zacc_q  <= zacc_q & alu_zero;
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        result  <= work_next;
                        cout    <= alu_cout;
                        zero    <= zacc_q & alu_zero;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_chunk_sequencer.sv
// tb/tb_alu_chunk_sequencer.sv - scoreboard bench for alu_chunk_sequencer with a behavioural ALU
module tb_alu_chunk_sequencer;

    localparam int TR = 4;
    localparam int NC = 4;
    localparam int W  = TR * NC;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin_in;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          cout;
    logic          zero;
    logic [TR-1:0] alu_a;
    logic [TR-1:0] alu_b;
    logic          alu_cin;
    logic          alu_op;
    logic [TR-1:0] alu_product;
    logic          alu_cout;
    logic          alu_zero;

    int total = 0;
    int bad   = 0;

    // expected {cout, zero, result} per accepted operation
    logic [W+1:0] exp_q[$];
    logic [W-1:0] shown_result;

    alu_chunk_sequencer #(.TERMINAL_RANGE(TR), .NUM_CHUNKS(NC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin_in(cin_in),
        .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
        .alu_product(alu_product), .alu_cout(alu_cout), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    // Behavioural narrow ALU slice
    logic [TR:0] alu_sum;
    always_comb begin
        alu_sum     = {1'b0, alu_a} + {1'b0, (alu_op ? ~alu_b : alu_b)} + {{TR{1'b0}}, alu_cin};
        alu_product = alu_sum[TR-1:0];
        alu_cout    = alu_sum[TR];
        alu_zero    = (alu_sum[TR-1:0] == '0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-word reference: subtraction is A + ~B + cin over the full width.
    function automatic logic [W+1:0] ref_op(input logic o, input logic [W-1:0] x,
                                            input logic [W-1:0] y, input logic c);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, (o ? ~y : y)} + {{W{1'b0}}, c};
        return {s[W], (s[W-1:0] == '0), s[W-1:0]};
    endfunction

    // Carry entering chunk k = carry out of the low k*TR bits of the wide sum.
    function automatic logic ref_chunk_cin(input logic o, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input logic c, input int k);
        logic [31:0] mask;
        logic [31:0] s;
        logic [W-1:0] yy;
        yy   = o ? ~y : y;
        mask = (32'h1 << (TR * k)) - 32'h1;
        s    = (32'(x) & mask) + (32'(yy) & mask) + 32'(c);
        return s[TR * k];
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                chk("result", 32'(result), 32'(e[W-1:0]));
                chk("cout", 32'(cout), 32'(e[W+1]));
                chk("zero", 32'(zero), 32'(e[W]));
            end
        end
    end

    // Issue one op; optionally pulse an ignored start on RUN cycle ign_k. Returns in the done cycle.
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input int ign_k);
        logic [W+1:0] e;
        e      = ref_op(o, x, y, c);
        op     = o;
        a      = x;
        b      = y;
        cin_in = c;
        start  = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start  = 1'b0;
        a      = W'($urandom);
        b      = W'($urandom);
        op     = 1'($urandom);
        cin_in = 1'($urandom);
        for (int k = 0; k < NC; k++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk("alu_op", 32'(alu_op), 32'(o));
            chk("alu_cin", 32'(alu_cin), 32'(ref_chunk_cin(o, x, y, c, k)));
            chk("result_hold", 32'(result), 32'(shown_result));
            if (k == ign_k) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("busy_done", 32'(busy), 32'd0);
        chk("done_pulse", 32'(done), 32'd1);
        shown_result = e[W-1:0];
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        chk("busy_idle", 32'(busy), 32'd0);
        chk("done_idle", 32'(done), 32'd0);
        chk("alu_a_idle", 32'(alu_a), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        op           = 1'b0;
        a            = '0;
        b            = '0;
        cin_in       = 1'b0;
        shown_result = '0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();

        run_op(1'b0, 16'h12FD, 16'h0104, 1'b0, -1);
        idle_cycle();
        run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, -1);
        idle_cycle();
        run_op(1'b1, 16'h1234, 16'h1234, 1'b1, -1);
        idle_cycle();
        run_op(1'b1, 16'h0005, 16'h0006, 1'b1, -1);
        idle_cycle();

        // ignored start mid-run, then back-to-back start held in the done cycle
        run_op(1'b0, 16'h0F0F, 16'h00F1, 1'b0, 2);
        run_op(1'b1, 16'h8000, 16'h0001, 1'b1, -1);
        idle_cycle();

        // asynchronous reset during chunk 2
        op     = 1'b0;
        a      = 16'hABCD;
        b      = 16'h1111;
        cin_in = 1'b1;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        chk("arst_zero", 32'(zero), 32'd0);
        #2;
        rst_n = 1'b1;
        shown_result = '0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("no_done_after_rst", 32'(done), 32'd0);
        end
        run_op(1'b0, 16'h0001, 16'h0001, 1'b0, -1);
        idle_cycle();

        // randomized operations, sometimes back-to-back
        for (int i = 0; i < 24; i++) begin
            run_op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom),
                   (($urandom % 3) == 0) ? int'($urandom_range(0, NC - 1)) : -1);
            if ($urandom % 2) idle_cycle();
        end
        idle_cycle();
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
